uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between a CPU write port and a UART transmitter.
// The CPU pushes bytes. A four-state drain FSM launches the head byte with a
// one-cycle tx_start pulse, then follows tx_busy through the whole frame.
// Optional build macro UART_TX_FIFO_CRLF_EN: when it is defined, a head byte of
// 8'h0A goes out as 8'h0D (the byte stays in the FIFO), then as 8'h0A (the byte
// is popped).
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level_nxt;
  logic [7:0]    head;
  logic          push, drop, pop;

  assign head = mem[rd_ptr];
  // full is registered, so a pop in the same cycle cannot make room for a push
  assign push = wr_en && !full;
  assign drop = wr_en && full;

`ifdef UART_TX_FIFO_CRLF_EN
  logic cr_sent;     // CR already sent for the LF byte at the head
  logic launch_pop;  // the launch now in progress pops the head byte
  logic cr_due;
  assign cr_due = (head == 8'h0A) && !cr_sent;
  assign pop    = (state == LAUNCH) && launch_pop;
`else
  assign pop    = (state == LAUNCH);
`endif

  // next level; a push and a pop in the same cycle cancel out
  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + (AW+1)'(1);
      2'b01:   level_nxt = level - (AW+1)'(1);
      default: level_nxt = level;
    endcase
  end

  // storage array; it has no reset because its contents are meaningless until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // pointers, level, status flags and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      // a dropped write wins over a clear in the same cycle
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // drain FSM: launch the head byte, then follow tx_busy as it rises and falls
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent    <= 1'b0;
      launch_pop <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // tx_busy also gates the launch, so tx_start never overlaps a busy transmitter
          if (!empty && !tx_busy) begin
            state    <= LAUNCH;
            tx_start <= 1'b1;
`ifdef UART_TX_FIFO_CRLF_EN
            if (cr_due) begin
              tx_data    <= 8'h0D;
              cr_sent    <= 1'b1;
              launch_pop <= 1'b0;
            end else begin
              tx_data    <= head;
              launch_pop <= 1'b1;
            end
`else
            tx_data  <= head;
`endif
          end
        end
        LAUNCH: begin
          tx_start <= 1'b0;
          state    <= WAIT_BUSY;
`ifdef UART_TX_FIFO_CRLF_EN
          if (launch_pop) cr_sent <= 1'b0;
`endif
        end
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=16). A transmitter model raises
// tx_busy one cycle after it samples tx_start and holds it for busy_len cycles.
// force_busy keeps tx_busy high so bytes pile up in the FIFO.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk, rst, wr_en, ovf_clr, tx_busy;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start;
  logic [4:0] level;
  logic [7:0] tx_data;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] out_q[$];
  logic [7:0] exp_q[$];
  bit         pend = 0, model_busy = 0, force_busy = 0;
  int         busy_cnt = 0, busy_len = 10;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // transmitter model and launch monitor, updated on the falling edge
  initial begin
    tx_busy = 0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        checks++;
        if (tx_busy !== 1'b0) begin
          failures++;
          $display("FAIL start_while_busy: tx_start with tx_busy=%b, required 0", tx_busy);
        end
        out_q.push_back(tx_data);
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        model_busy = (busy_cnt != 0);
      end
      if (pend) begin
        pend = 0;
        model_busy = 1;
        busy_cnt = busy_len;
      end
      if (tx_start === 1'b1) pend = 1;
      tx_busy = model_busy | force_busy;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1; wr_data = d;
    step();
    wr_en = 0;
  endtask

  task automatic wait_start(input string nm);
    for (int i = 0; i < 40 && tx_start !== 1'b1; i++) step();
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: tx_start=%b, required 1", nm, tx_start);
    end
  endtask

  task automatic drain(input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      step();
      if (empty && !tx_busy && !pend && busy_cnt == 0 && !tx_start) ok = 1;
    end
    step(); step();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain_timeout: empty=%b tx_busy=%b, required 1/0", nm, empty, tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 1; wr_data = 8'hAA; ovf_clr = 0;
    step(); step();
    rst = 0; wr_en = 0;
    checks++;
    if ({level, empty, full, overflow, tx_start, tx_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: level=%0d empty=%b full=%b ovf=%b start=%b data=%h, required 0 1 0 0 0 00",
               level, empty, full, overflow, tx_start, tx_data);
    end
    step();
    checks++;
    if (level !== 0 || tx_start !== 0) begin
      failures++;
      $display("FAIL reset_hold: level=%0d tx_start=%b, required 0 0", level, tx_start);
    end
  endtask

  task automatic test_single();
    out_q.delete();
    busy_len = 10;
    push(8'h41);
    checks++;
    if (empty !== 0 || level !== 1 || tx_start !== 0) begin
      failures++;
      $display("FAIL single_after_push: empty=%b level=%0d start=%b, required 0 1 0", empty, level, tx_start);
    end
    step();
    checks++;
    if (tx_start !== 1 || tx_data !== 8'h41) begin
      failures++;
      $display("FAIL single_latency: start=%b data=%h, required 1 41", tx_start, tx_data);
    end
    step();
    checks++;
    if (tx_start !== 0 || level !== 0) begin
      failures++;
      $display("FAIL single_one_pulse: start=%b level=%0d, required 0 0", tx_start, level);
    end
    drain("single");
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 8'h41 || level !== 0) begin
      failures++;
      $display("FAIL single_sent: count=%0d level=%0d, required 1 byte 41 level 0", out_q.size(), level);
    end
  endtask

  task automatic test_full_overflow();
    out_q.delete();
    busy_len = 4;
    force_busy = 1;
    step();
    for (int i = 0; i < 16; i++) push(8'(i));
    checks++;
    if (full !== 1 || level !== 16 || overflow !== 0) begin
      failures++;
      $display("FAIL full_flags: full=%b level=%0d ovf=%b, required 1 16 0", full, level, overflow);
    end
    push(8'hFF);
    checks++;
    if (overflow !== 1 || level !== 16) begin
      failures++;
      $display("FAIL overflow_set: ovf=%b level=%0d, required 1 16", overflow, level);
    end
    ovf_clr = 1; step(); ovf_clr = 0;
    checks++;
    if (overflow !== 0) begin
      failures++;
      $display("FAIL ovf_clr: ovf=%b, required 0", overflow);
    end
    ovf_clr = 1; push(8'hFE); ovf_clr = 0;
    checks++;
    if (overflow !== 1 || level !== 16) begin
      failures++;
      $display("FAIL ovf_clr_vs_drop: ovf=%b level=%0d, required 1 16", overflow, level);
    end
    ovf_clr = 1; step(); ovf_clr = 0;
    force_busy = 0;
    wait_start("full");
    checks++;
    if (tx_data !== 8'h00) begin
      failures++;
      $display("FAIL full_first_byte: data=%h, required 00", tx_data);
    end
    // push during the pop cycle while full: still dropped
    push(8'hEE);
    checks++;
    if (level !== 15 || full !== 0 || overflow !== 1) begin
      failures++;
      $display("FAIL full_push_with_pop: level=%0d full=%b ovf=%b, required 15 0 1", level, full, overflow);
    end
    drain("full");
    checks++;
    if (out_q.size() != 16) begin
      failures++;
      $display("FAIL full_count: sent=%0d, required 16", out_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (out_q[i] !== 8'(i)) begin
          failures++;
          $display("FAIL full_order[%0d]: got %h, required %h", i, out_q[i], 8'(i));
        end
      end
    end
    ovf_clr = 1; step(); ovf_clr = 0;
  endtask

  task automatic test_push_pop_same();
    out_q.delete();
    force_busy = 1;
    step();
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    force_busy = 0;
    wait_start("pp");
    push(8'h15);
    checks++;
    if (level !== 5) begin
      failures++;
      $display("FAIL push_pop_level: level=%0d, required 5", level);
    end
    drain("pp");
    checks++;
    if (out_q.size() != 6) begin
      failures++;
      $display("FAIL push_pop_count: sent=%0d, required 6", out_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (out_q[i] !== 8'h10 + 8'(i)) begin
          failures++;
          $display("FAIL push_pop_order[%0d]: got %h, required %h", i, out_q[i], 8'h10 + 8'(i));
        end
      end
    end
  endtask

  task automatic test_reset_wait_done();
    out_q.delete();
    busy_len = 12;
    force_busy = 1;
    step();
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    force_busy = 0;
    wait_start("rwd");
    for (int i = 0; i < 10 && tx_busy !== 1'b1; i++) step();
    step();
    checks++;
    if (level !== 3 || tx_busy !== 1) begin
      failures++;
      $display("FAIL rwd_pre: level=%0d busy=%b, required 3 1", level, tx_busy);
    end
    rst = 1; wr_en = 1; wr_data = 8'h77; ovf_clr = 1;
    step();
    rst = 0; wr_en = 0; ovf_clr = 0;
    checks++;
    if (level !== 0 || empty !== 1 || tx_start !== 0) begin
      failures++;
      $display("FAIL rwd_reset: level=%0d empty=%b start=%b, required 0 1 0", level, empty, tx_start);
    end
    out_q.delete();
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (out_q.size() != 0) begin
      failures++;
      $display("FAIL rwd_no_reissue: launches=%0d, required 0", out_q.size());
    end
    drain("rwd_idle");
    push(8'h55);
    drain("rwd");
    checks++;
    if (out_q.size() != 1 || out_q[0] !== 8'h55) begin
      failures++;
      $display("FAIL rwd_next_push: count=%0d, required 1 byte 55", out_q.size());
    end
  endtask

  task automatic test_crlf();
    logic [7:0] exp[$];
`ifdef UART_TX_FIFO_CRLF_EN
    exp = '{8'h41, 8'h0D, 8'h0A};
`else
    exp = '{8'h41, 8'h0A};
`endif
    out_q.delete();
    busy_len = 3;
    force_busy = 1;
    step();
    push(8'h41);
    push(8'h0A);
    checks++;
    if (level !== 2) begin
      failures++;
      $display("FAIL crlf_level: level=%0d, required 2", level);
    end
    force_busy = 0;
    drain("crlf");
    checks++;
    if (out_q.size() != exp.size()) begin
      failures++;
      $display("FAIL crlf_count: sent=%0d, required %0d", out_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (out_q[i] !== exp[i]) begin
          failures++;
          $display("FAIL crlf_seq[%0d]: got %h, required %h", i, out_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int pushed, lat_fail, bad;
    logic [7:0] d;
    out_q.delete();
    exp_q.delete();
    busy_len = 3;
    pushed = 0; lat_fail = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      d = 8'($urandom_range(0, 255));
      if (d == 8'h0A) d = 8'h0B;
      if (pushed == out_q.size() && !tx_busy && !pend && busy_cnt == 0 && !tx_start
          && $urandom_range(0, 3) == 0) begin
        // latency check into an empty, idle FIFO
        exp_q.push_back(d); pushed++;
        push(d);
        checks++;
        if (empty !== 0 || tx_start !== 0) begin
          failures++;
          $display("FAIL rand_lat_push: empty=%b start=%b, required 0 0", empty, tx_start);
        end
        step();
        checks++;
        if (tx_start !== 1 || tx_data !== d) begin
          failures++;
          lat_fail++;
          if (lat_fail < 5)
            $display("FAIL rand_lat_start: start=%b data=%h, required 1 %h", tx_start, tx_data, d);
        end
      end else if ((pushed - out_q.size()) < DEPTH - 2 && $urandom_range(0, 5) == 0) begin
        exp_q.push_back(d); pushed++;
        push(d);
      end else begin
        step();
      end
    end
    drain("rand");
    checks++;
    if (out_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: sent=%0d, required %0d", out_q.size(), exp_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (out_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL rand_order: %0d bytes out of order, required 0", bad);
      end
    end
  endtask

  initial begin
    rst = 1; wr_en = 0; wr_data = 0; ovf_clr = 0;
    test_reset();
    test_single();
    test_full_overflow();
    test_push_pop_same();
    test_reset_wait_done();
    test_crlf();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
